// File: rtl/rom_scan_ctrl.sv
// Glyph/text ROM sequencer: walks the 8-entry ROM, latches glyphs onto the segment
// output and streams paired text bytes over valid/ready. Optional macro: SKIP_BLANK_EN.
module rom_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         rom_data1,
  input  logic [7:0]         rom_data2,
  output logic [IDX_W-1:0]   rom_addr,
  output logic [7:0]         seg_out,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               step,
  output logic               wrap
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] DWELL = 2'd3;

  logic [1:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic               blank;
  logic               last_idx;

  assign last_idx = &rom_addr;

`ifdef SKIP_BLANK_EN
  // an all-dark glyph is skipped in a single cycle without touching the stream
  assign blank = (rom_data1 == 8'h00);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      seg_out  <= 8'h00;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      cnt      <= '0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          if (blank) begin
            rom_addr <= rom_addr + 1'b1;
            step     <= 1'b1;
            wrap     <= last_idx;
            state    <= en ? LOAD : IDLE;
          end else begin
            seg_out  <= rom_data1;
            tx_data  <= rom_data2;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        // tx_valid only drops on a handshake, regardless of en
        SEND: if (tx_ready) begin
          tx_valid <= 1'b0;
          cnt      <= dwell;
          state    <= DWELL;
        end
        DWELL: begin
          if (cnt == '0) begin
            rom_addr <= rom_addr + 1'b1;
            step     <= 1'b1;
            wrap     <= last_idx;
            state    <= en ? LOAD : IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl with a behavioural 8-entry ROM.
module tb_rom_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       en = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [7:0] rom_data1, rom_data2;
  logic [2:0] rom_addr;
  logic [7:0] seg_out, tx_data;
  logic       tx_valid, step, wrap;
  logic       tx_ready = 1'b1;

  int passed = 0, total = 0;
  int hs_cnt = 0, exp_hs = 0;
  int n;

  logic [7:0] G [8] = '{8'h6F, 8'h00, 8'h39, 8'h30, 8'h31, 8'h37, 8'h3F, 8'h00};
  logic [7:0] T [8] = '{8'h42, 8'h41, 8'h4B, 8'h41, 8'h42, 8'h41, 8'h4B, 8'h41};

  assign rom_data1 = G[rom_addr];
  assign rom_data2 = T[rom_addr];

  rom_scan_ctrl #(.DWELL_W(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .dwell(dwell),
    .rom_data1(rom_data1), .rom_data2(rom_data2), .rom_addr(rom_addr),
    .seg_out(seg_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && tx_valid && tx_ready) hs_cnt <= hs_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic is_blank(input int idx);
`ifdef SKIP_BLANK_EN
    return G[idx] == 8'h00;
`else
    return 1'b0;
`endif
  endfunction

  // precondition: in LOAD at index idx, dwell=0, tx_ready=1, en=1
  task automatic do_step(input int idx);
    logic [2:0] nxt;
    nxt = 3'((idx + 1) % 8);
    if (is_blank(idx)) begin
      tick();
      chk($sformatf("blank_step%0d", idx), step, 1);
      chk($sformatf("blank_wrap%0d", idx), wrap, idx == 7);
      chk($sformatf("blank_addr%0d", idx), rom_addr, nxt);
      chk($sformatf("blank_txv%0d", idx), tx_valid, 0);
    end else begin
      tick();
      chk($sformatf("seg%0d", idx), seg_out, G[idx]);
      chk($sformatf("txd%0d", idx), tx_data, T[idx]);
      chk($sformatf("txv%0d", idx), tx_valid, 1);
      chk($sformatf("nostep_load%0d", idx), step, 0);
      tick();
      chk($sformatf("txv_drop%0d", idx), tx_valid, 0);
      chk($sformatf("nostep_send%0d", idx), step, 0);
      tick();
      chk($sformatf("step%0d", idx), step, 1);
      chk($sformatf("wrap%0d", idx), wrap, idx == 7);
      chk($sformatf("addr%0d", idx), rom_addr, nxt);
      exp_hs++;
    end
  endtask

  task automatic count_to_step(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cycles++;
      if (step) break;
    end
  endtask

  initial begin
    rst = 1'b1;
    #3;
    chk("rst_addr", rom_addr, 0);
    chk("rst_seg", seg_out, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_step", {step, wrap}, 0);
    tick();
    rst = 1'b0;
    en = 1'b1;
    tick();
    chk("idle_to_load_txv", tx_valid, 0);
    chk("idle_addr", rom_addr, 0);

    // full pass over all 8 entries
    for (int k = 0; k < 8; k++) do_step(k);

    // backpressure on index 2
    do_step(0);
    do_step(1);
    tx_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid%0d", c), tx_valid, 1);
      chk($sformatf("bp_data%0d", c), tx_data, 8'h4B);
      if (c < 4) tick();
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_accept", tx_valid, 0);
    tick();
    chk("bp_step", step, 1);
    chk("bp_addr", rom_addr, 3);
    exp_hs++;
    chk("bp_hs_count", hs_cnt, exp_hs);

    // dwell=3 gives a 6-cycle step; dwell changes mid-DWELL are ignored
    dwell = 8'd3;
    count_to_step(n);
    chk("dwell3_period", n, 6);
    tick();
    tick();
    dwell = 8'd0;
    count_to_step(n);
    chk("dwell_change_rest", n, 4);
    count_to_step(n);
    chk("dwell0_period", n, 3);
    chk("dwell_addr", rom_addr, 6);
    exp_hs += 3;

    // advance to index 4
    for (int k = 6; k < 12; k++) do_step(k % 8);
    chk("pre_drop_addr", rom_addr, 4);

    // drop en during SEND at index 4
    tick();
    chk("drop_seg", seg_out, 8'h31);
    en = 1'b0;
    tx_ready = 1'b0;
    tick();
    chk("drop_hold_valid", tx_valid, 1);
    chk("drop_hold_data", tx_data, 8'h42);
    tx_ready = 1'b1;
    tick();
    chk("drop_accept", tx_valid, 0);
    tick();
    chk("drop_step", step, 1);
    chk("drop_addr", rom_addr, 5);
    exp_hs++;
    tick();
    tick();
    chk("idle_nostep", step, 0);
    chk("idle_addr5", rom_addr, 5);
    chk("idle_txv", tx_valid, 0);
    chk("idle_seg_hold", seg_out, 8'h31);
    en = 1'b1;
    tick();
    chk("resume_txv0", tx_valid, 0);
    tick();
    chk("resume_seg", seg_out, 8'h37);
    chk("resume_txd", tx_data, 8'h41);
    chk("resume_txv", tx_valid, 1);
    chk("hs_total", hs_cnt, exp_hs);

    // asynchronous reset while in SEND at index 5
    tx_ready = 1'b0;
    tick();
    chk("presrst_addr", rom_addr, 5);
    chk("presrst_valid", tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", rom_addr, 0);
    chk("arst_seg", seg_out, 0);
    chk("arst_txd", tx_data, 0);
    chk("arst_txv", tx_valid, 0);
    chk("arst_pulses", {step, wrap}, 0);
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    tick();
    chk("post_rst_txv", tx_valid, 0);
    tick();
    chk("post_rst_seg", seg_out, 8'h6F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/rom_scan_ctrl.md
Name: rom_scan_ctrl

Overview:
Sequencer for the 8-entry glyph/byte ROM. It steps the ROM address 0..7 and wraps. At each step it latches the glyph byte (data1) onto the segment output and offers the paired text byte (data2) on a valid/ready byte stream. A programmable dwell sets how long each glyph is held. It sits between the ROM and the display and serial-out logic of the art project.

Parameters:
DWELL_W, 8, width of dwell input and dwell counter
IDX_W, 3, ROM address width (8 entries); wrap is at 2^IDX_W-1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  run enable, level-sensitive
dwell  in  DWELL_W  hold count per step; DWELL state lasts dwell+1 cycles
rom_data1  in  8  glyph byte from ROM (combinational w.r.t. rom_addr)
rom_data2  in  8  text byte from ROM (combinational w.r.t. rom_addr)
rom_addr  out  IDX_W  registered ROM address = current index
seg_out  out  8  latched glyph byte
tx_data  out  8  text byte offered downstream
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts when tx_valid&tx_ready at clock edge
step  out  1  one-cycle pulse when the index advances
wrap  out  1  one-cycle pulse with step when the index goes 7->0

Behaviour:
- Reset (async, any state): state=IDLE, rom_addr=0, seg_out=0x00, tx_data=0x00, tx_valid=0, step=0, wrap=0, dwell counter=0.
- States: IDLE, LOAD, SEND, DWELL.
- IDLE: outputs hold. Edge with en=1 -> LOAD. rom_addr keeps the last index; it does not return to 0 except on reset.
- LOAD (1 cycle): ROM reads rom_addr. At the edge: seg_out<=rom_data1, tx_data<=rom_data2, tx_valid<=1, next state SEND. en is ignored in LOAD.
- SEND: tx_valid=1 and tx_data stable until handshake. On an edge with tx_ready=1: tx_valid<=0, counter<=dwell, next state DWELL. tx_valid never drops without a handshake, even if en falls.
- DWELL: counter decrements each edge. Edge with counter==0:
  - rom_addr<=rom_addr+1 (mod 8); step=1 for that next cycle; wrap=1 if the old index was 7.
  - Next state is LOAD if en=1, else IDLE.
- Cycles per step = 1 (LOAD) + SEND cycles (>=1) + dwell+1. With tx_ready held high and dwell=0, a step takes 3 cycles.
- dwell is sampled only on SEND->DWELL entry. Changes during DWELL do not affect the current step.
- en falling mid-step: the current step completes, including handshake and dwell, then the block parks in IDLE with the index already advanced.
- step and wrap are registered pulses, high exactly one cycle; both are 0 in all other cycles.

Optional Feature:
SKIP_BLANK_EN
- Defined: in LOAD, if rom_data1==0x00 the entry is blank. seg_out and tx_data are not updated and tx_valid stays 0. The index advances at that edge, with step/wrap pulses as normal. Next state is LOAD if en=1, else IDLE. A blank entry costs 1 cycle.
- Undefined: every entry, including 0x00 glyphs, is latched and sent.
- If all 8 entries are blank, the block cycles LOAD forever with step pulses and no tx traffic. This is legal.

Test Plan:
- Reset mid-SEND (tx_valid=1, rom_addr=5), then assert rst -> all outputs immediately 0 and state IDLE, with no clock needed.
- en=1, dwell=0, tx_ready=1, macro off, 8 steps from reset:
  - seg_out = 6F,00,39,30,31,37,3F,00
  - tx bytes = 42,41,4B,41,42,41,4B,41
  - step every 3 cycles; wrap on the 8th step only.
- Backpressure: tx_ready low 5 cycles at step 2 -> tx_valid=1 and tx_data=0x4B held for all 5 cycles; byte accepted once; no duplicate or lost bytes.
- dwell=3, tx_ready=1 -> step period 6 cycles. Change dwell to 0 mid-DWELL -> the current step still takes 6 cycles; the next takes 3.
- Drop en during SEND at index 4 -> handshake completes, dwell completes, rom_addr=5, state IDLE. Re-raise en -> next seg_out=0x37, tx byte 0x41.
- SKIP_BLANK_EN defined, dwell=0, tx_ready=1:
  - seg_out = 6F,39,30,31,37,3F
  - tx bytes = 42,4B,41,42,41,4B
  - steps at indices 1 and 7 occur 1 cycle after the prior step; wrap still pulses at 7->0.
